// File: rtl/biu_pkg.sv
// biu_pkg: T-state encoding, linear-address helper and parameter legality checks
package biu_pkg;

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} tstate_t;

    function automatic logic [19:0] linear_addr(input logic [15:0] seg, input logic [15:0] off);
        return {seg, 4'h0} + {4'h0, off};
    endfunction

    function automatic bit dbytes_ok(input int d);
        return d == 1 || d == 2;
    endfunction

    function automatic bit qdepth_ok(input int q);
        return q == 4 || q == 8 || q == 16;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: byte-plus-address queue with a 0/1/2-byte write port and a 1-byte read port
module prefetch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic [1:0]               i_wr_n,
    input  logic [7:0]               i_wr_d0,
    input  logic [19:0]              i_wr_a0,
    input  logic [7:0]               i_wr_d1,
    input  logic [19:0]              i_wr_a1,
    input  logic                     i_rd,
    output logic [7:0]               o_rd_d,
    output logic [19:0]              o_rd_a,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_dat [DEPTH];
    logic [19:0]   r_adr [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_wp1;
    logic          w_pop;

    assign w_wp1 = r_wp + 1'b1;
    assign w_pop = i_rd && r_cnt != '0;

    // storage: the first written byte lands at the write pointer, the second just after it
    always_ff @(posedge i_clk) begin
        if (i_wr_n != 2'd0) begin
            r_dat[r_wp] <= i_wr_d0;
            r_adr[r_wp] <= i_wr_a0;
        end
        if (i_wr_n == 2'd2) begin
            r_dat[w_wp1] <= i_wr_d1;
            r_adr[w_wp1] <= i_wr_a1;
        end
    end

    // pointers and occupancy; a clear overrides any same-cycle write or read
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + AW'(i_wr_n);
            r_rp  <= r_rp + AW'(w_pop);
            r_cnt <= r_cnt + CW'(i_wr_n) - CW'(w_pop);
        end
    end

    assign o_rd_d  = r_cnt == '0 ? 8'h00 : r_dat[r_rp];
    assign o_rd_a  = r_cnt == '0 ? 20'h0 : r_adr[r_rp];
    assign o_count = r_cnt;

endmodule

// File: rtl/prefetch_bus_unit.sv
// prefetch_bus_unit: 8088/8086-style instruction prefetch bus cycle engine feeding a byte queue
module prefetch_bus_unit
    import biu_pkg::*;
#(
    parameter int DBYTES = 1,
    parameter int QDEPTH = 4
) (
    input  logic                     CLKx4,
    input  logic                     RESET,
    input  logic                     TICK,
    input  logic                     READY,
    input  logic [8*DBYTES-1:0]      inD,
    output logic [19:0]              A,
    output logic                     ALE,
    output logic                     RD_n,
    output logic                     BHE_n,
    input  logic                     flush,
    input  logic [15:0]              newCS,
    input  logic [15:0]              newIP,
    input  logic                     suspend,
    input  logic                     advanceTop,
    output logic [7:0]               prefetchTop,
    output logic [19:0]              prefetchTopLinearAddress,
    output logic                     prefetchEmpty,
    output logic                     prefetchFull,
    output logic [$clog2(QDEPTH):0]  qCount
);
    localparam int CW = $clog2(QDEPTH) + 1;

    if (!dbytes_ok(DBYTES)) begin : g_bad_dbytes
        $error("prefetch_bus_unit: DBYTES must be 1 or 2");
    end
    if (!qdepth_ok(QDEPTH)) begin : g_bad_qdepth
        $error("prefetch_bus_unit: QDEPTH must be 4, 8 or 16");
    end

    tstate_t       r_state, w_next;
    logic [15:0]   r_cs, r_ip;
    logic          r_discard;
    logic [19:0]   r_a;
    logic          r_ale, r_rd_n, r_bhe_n;
    logic [1:0]    w_fsize, w_wr_n;
    logic [CW-1:0] w_free;
    logic          w_start, w_done, w_push, w_hi;
    logic [15:0]   w_d16;

    assign w_d16   = 16'(inD);
    assign w_fsize = (DBYTES == 2 && !r_ip[0]) ? 2'd2 : 2'd1;
    assign w_free  = CW'(QDEPTH) - qCount;
    assign w_start = TICK && r_state == S_IDLE && !suspend && !flush && w_free >= CW'(w_fsize);
    assign w_done  = TICK && READY && (r_state == S_T3 || r_state == S_TW);
    assign w_push  = w_done && !r_discard && !flush;
    assign w_hi    = DBYTES == 2 && r_ip[0];
    assign w_wr_n  = w_push ? w_fsize : 2'd0;

    // T-state sequencing; nothing moves without TICK
    always_comb begin
        w_next = r_state;
        if (TICK) begin
            case (r_state)
                S_IDLE:     w_next = w_start ? S_T1 : S_IDLE;
                S_T1:       w_next = S_T2;
                S_T2:       w_next = S_T3;
                S_T3, S_TW: w_next = READY ? S_T4 : S_TW;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    // state register plus registered bus strobes derived from the state being entered
    always_ff @(posedge CLKx4) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_ale   <= 1'b0;
            r_rd_n  <= 1'b1;
            r_bhe_n <= 1'b1;
        end else if (TICK) begin
            r_state <= w_next;
            r_ale   <= w_next == S_T1;
            r_rd_n  <= !(w_next inside {S_T2, S_T3, S_TW});
            if (w_start) begin
                r_a     <= linear_addr(r_cs, r_ip);
                r_bhe_n <= !(DBYTES == 2 && (r_ip[0] || w_fsize == 2'd2));
            end
        end
    end

    // fetch pointer; a flush during an open cycle marks that cycle's data as stale
    always_ff @(posedge CLKx4) begin
        if (RESET) begin
            r_cs      <= 16'hFFFF;
            r_ip      <= 16'h0000;
            r_discard <= 1'b0;
        end else if (flush) begin
            r_cs      <= newCS;
            r_ip      <= newIP;
            r_discard <= (r_state inside {S_T1, S_T2, S_T3, S_TW}) && !w_done;
        end else begin
            if (w_done) r_discard <= 1'b0;
            if (w_push) r_ip <= r_ip + 16'(w_fsize);
        end
    end

    prefetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .i_clk   (CLKx4),
        .i_rst   (RESET),
        .i_clr   (flush),
        .i_wr_n  (w_wr_n),
        .i_wr_d0 (w_hi ? w_d16[15:8] : w_d16[7:0]),
        .i_wr_a0 (linear_addr(r_cs, r_ip)),
        .i_wr_d1 (w_d16[15:8]),
        .i_wr_a1 (linear_addr(r_cs, r_ip + 16'd1)),
        .i_rd    (advanceTop),
        .o_rd_d  (prefetchTop),
        .o_rd_a  (prefetchTopLinearAddress),
        .o_count (qCount)
    );

    assign A             = r_a;
    assign ALE           = r_ale;
    assign RD_n          = r_rd_n;
    assign BHE_n         = r_bhe_n;
    assign prefetchEmpty = qCount == '0;
    assign prefetchFull  = qCount == CW'(QDEPTH);

endmodule

// File: tb/tb_prefetch_bus_unit.sv
// tb_prefetch_bus_unit: scenario bench for the 8088 and 8086 configurations side by side
module tb_prefetch_bus_unit;
    logic        clk = 1'b0, rst = 1'b1, tick = 1'b1, ready = 1'b1;
    logic        flush = 1'b0, suspend = 1'b0, adv = 1'b0;
    logic [15:0] new_cs = 16'h0, new_ip = 16'h0;
    logic [7:0]  d8_ind;
    logic [15:0] d16_ind;
    logic [19:0] d8_a, d16_a, d8_topa, d16_topa;
    logic        d8_ale, d8_rd_n, d8_bhe_n, d8_empty, d8_full;
    logic        d16_ale, d16_rd_n, d16_bhe_n, d16_empty, d16_full;
    logic [7:0]  d8_top, d16_top;
    logic [2:0]  d8_cnt, d16_cnt;
    logic [27:0] sb[$];
    logic [27:0] sb8[$];
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mb(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [19:0] lin(input logic [15:0] s, input logic [15:0] o);
        return {s, 4'h0} + {4'h0, o};
    endfunction

    assign d8_ind  = mb(d8_a);
    assign d16_ind = {mb(d16_a | 20'h1), mb(d16_a & ~20'h1)};

    prefetch_bus_unit #(.DBYTES(1), .QDEPTH(4)) u_d8 (
        .CLKx4(clk), .RESET(rst), .TICK(tick), .READY(ready), .inD(d8_ind),
        .A(d8_a), .ALE(d8_ale), .RD_n(d8_rd_n), .BHE_n(d8_bhe_n),
        .flush(flush), .newCS(new_cs), .newIP(new_ip), .suspend(suspend), .advanceTop(adv),
        .prefetchTop(d8_top), .prefetchTopLinearAddress(d8_topa),
        .prefetchEmpty(d8_empty), .prefetchFull(d8_full), .qCount(d8_cnt)
    );

    prefetch_bus_unit #(.DBYTES(2), .QDEPTH(4)) u_d16 (
        .CLKx4(clk), .RESET(rst), .TICK(tick), .READY(ready), .inD(d16_ind),
        .A(d16_a), .ALE(d16_ale), .RD_n(d16_rd_n), .BHE_n(d16_bhe_n),
        .flush(flush), .newCS(new_cs), .newIP(new_ip), .suspend(suspend), .advanceTop(adv),
        .prefetchTop(d16_top), .prefetchTopLinearAddress(d16_topa),
        .prefetchEmpty(d16_empty), .prefetchFull(d16_full), .qCount(d16_cnt)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_flush(input logic [15:0] cs, input logic [15:0] ip);
        flush = 1'b1; new_cs = cs; new_ip = ip;
        step(1);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b1; suspend = 1'b0;
        step(3);
        n_cmp++;
        if ({d8_a, d8_ale, d8_rd_n, d8_bhe_n, d8_cnt, d8_top, d8_topa} !== {20'h0, 3'b011, 3'd0, 8'h0, 20'h0}) begin
            n_err++;
            $display("FAIL reset_d8: got a=%h ale=%b rd=%b bhe=%b cnt=%0d top=%h topa=%h, want all idle/zero", d8_a, d8_ale, d8_rd_n, d8_bhe_n, d8_cnt, d8_top, d8_topa);
        end
        n_cmp++;
        if ({d16_a, d16_ale, d16_rd_n, d16_bhe_n, d16_cnt, d16_top, d16_topa} !== {20'h0, 3'b011, 3'd0, 8'h0, 20'h0}) begin
            n_err++;
            $display("FAIL reset_d16: got a=%h ale=%b rd=%b bhe=%b cnt=%0d top=%h topa=%h, want all idle/zero", d16_a, d16_ale, d16_rd_n, d16_bhe_n, d16_cnt, d16_top, d16_topa);
        end
        n_cmp++;
        if ({d8_empty, d8_full, d16_empty, d16_full} !== 4'b1010) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 1010", {d8_empty, d8_full, d16_empty, d16_full});
        end
    endtask

    task automatic test_fill_8088();
        logic [27:0] e;
        int          seen;
        rst = 1'b0;
        step(1);
        for (int f = 0; f < 4; f++) begin
            n_cmp++;
            if (d8_ale !== 1'b1 || d8_a !== lin(16'hFFFF, 16'(f)) || d8_bhe_n !== 1'b1) begin
                n_err++;
                $display("FAIL fill_t1_%0d: ale=%b a=%h bhe=%b want 1 %h 1", f, d8_ale, d8_a, d8_bhe_n, lin(16'hFFFF, 16'(f)));
            end
            sb8.push_back({mb(lin(16'hFFFF, 16'(f))), lin(16'hFFFF, 16'(f))});
            step(1);
            n_cmp++;
            if (d8_rd_n !== 1'b0 || d8_ale !== 1'b0) begin
                n_err++;
                $display("FAIL fill_t2_%0d: rd=%b ale=%b want 0 0", f, d8_rd_n, d8_ale);
            end
            step(2);
            n_cmp++;
            if (d8_rd_n !== 1'b1 || d8_cnt !== 3'(f + 1)) begin
                n_err++;
                $display("FAIL fill_t4_%0d: rd=%b cnt=%0d want 1 %0d", f, d8_rd_n, d8_cnt, f + 1);
            end
            step(2);
        end
        n_cmp++;
        if (d8_ale !== 1'b0 || d8_full !== 1'b1) begin
            n_err++;
            $display("FAIL fill_full: ale=%b full=%b want 0 1", d8_ale, d8_full);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (d8_ale !== 1'b0 || d8_rd_n !== 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL fill_idle: bus activity in %0d cycles want 0", seen);
        end
        suspend = 1'b1;
        while (sb8.size() > 0) begin
            e = sb8.pop_front();
            n_cmp++;
            if (d8_top !== e[27:20] || d8_topa !== e[19:0]) begin
                n_err++;
                $display("FAIL fill_pop: got %h@%h want %h@%h", d8_top, d8_topa, e[27:20], e[19:0]);
            end
            adv = 1'b1; step(1); adv = 1'b0;
        end
        adv = 1'b1; step(1); adv = 1'b0;
        n_cmp++;
        if (d8_cnt !== 3'd0 || d8_empty !== 1'b1 || d16_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL pop_empty: d8 cnt=%0d empty=%b d16 cnt=%0d want 0 1 0", d8_cnt, d8_empty, d16_cnt);
        end
    endtask

    task automatic test_drain();
        logic [27:0] e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (d16_top !== e[27:20] || d16_topa !== e[19:0]) begin
                n_err++;
                $display("FAIL drain: got %h@%h want %h@%h", d16_top, d16_topa, e[27:20], e[19:0]);
            end
            adv = 1'b1; step(1); adv = 1'b0;
        end
        n_cmp++;
        if (d16_empty !== 1'b1 || d16_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL drain_empty: empty=%b cnt=%0d want 1 0", d16_empty, d16_cnt);
        end
    endtask

    task automatic test_flush_odd();
        int seen;
        do_flush(16'h1000, 16'h0003);
        suspend = 1'b0;
        n_cmp++;
        if (d16_cnt !== 3'd0 || d16_empty !== 1'b1) begin
            n_err++;
            $display("FAIL odd_flush: cnt=%0d empty=%b want 0 1", d16_cnt, d16_empty);
        end
        step(1);
        n_cmp++;
        if (d16_a !== 20'h10003 || d16_ale !== 1'b1 || d16_bhe_n !== 1'b0) begin
            n_err++;
            $display("FAIL odd_t1: a=%h ale=%b bhe=%b want 10003 1 0", d16_a, d16_ale, d16_bhe_n);
        end
        sb.push_back({mb(20'h10003), 20'h10003});
        step(3);
        n_cmp++;
        if (d16_cnt !== 3'd1 || d16_rd_n !== 1'b1) begin
            n_err++;
            $display("FAIL odd_push: cnt=%0d rd=%b want 1 1", d16_cnt, d16_rd_n);
        end
        step(2);
        n_cmp++;
        if (d16_a !== 20'h10004 || d16_ale !== 1'b1 || d16_bhe_n !== 1'b0) begin
            n_err++;
            $display("FAIL word_t1: a=%h ale=%b bhe=%b want 10004 1 0", d16_a, d16_ale, d16_bhe_n);
        end
        sb.push_back({mb(20'h10004), 20'h10004});
        sb.push_back({mb(20'h10005), 20'h10005});
        step(3);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (d16_ale !== 1'b0) seen++;
        end
        n_cmp++;
        if (d16_cnt !== 3'd3 || seen != 0) begin
            n_err++;
            $display("FAIL word_count: cnt=%0d starts=%0d want 3 0", d16_cnt, seen);
        end
        suspend = 1'b1;
        test_drain();
    endtask

    task automatic test_wait_states();
        int low;
        bit done;
        do_flush(16'h2000, 16'h0010);
        suspend = 1'b0;
        step(1);
        n_cmp++;
        if (d16_a !== 20'h20010 || d16_ale !== 1'b1) begin
            n_err++;
            $display("FAIL wait_t1: a=%h ale=%b want 20010 1", d16_a, d16_ale);
        end
        sb.push_back({mb(20'h20010), 20'h20010});
        sb.push_back({mb(20'h20011), 20'h20011});
        tick = 1'b0;
        step(3);
        n_cmp++;
        if (d16_ale !== 1'b1 || d16_a !== 20'h20010 || d16_rd_n !== 1'b1) begin
            n_err++;
            $display("FAIL tick_hold: ale=%b a=%h rd=%b want 1 20010 1", d16_ale, d16_a, d16_rd_n);
        end
        tick = 1'b1;
        low = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(1);
            if (d16_rd_n === 1'b0) low++;
            else if (low > 0) done = 1'b1;
            ready = !(low >= 2 && low <= 4);
        end
        ready = 1'b1;
        suspend = 1'b1;
        n_cmp++;
        if (!done || low != 5 || d16_cnt !== 3'd2) begin
            n_err++;
            $display("FAIL wait_rd: done=%b low_ticks=%0d cnt=%0d want 1 5 2", done, low, d16_cnt);
        end
        test_drain();
    endtask

    task automatic test_flush_t2();
        do_flush(16'h3000, 16'h0020);
        suspend = 1'b0;
        step(1);
        n_cmp++;
        if (d16_a !== 20'h30020 || d16_ale !== 1'b1) begin
            n_err++;
            $display("FAIL ft2_t1: a=%h ale=%b want 30020 1", d16_a, d16_ale);
        end
        step(1);
        do_flush(16'h3000, 16'h0100);
        n_cmp++;
        if (d16_cnt !== 3'd0 || d16_rd_n !== 1'b0) begin
            n_err++;
            $display("FAIL ft2_t3: cnt=%0d rd=%b want 0 0", d16_cnt, d16_rd_n);
        end
        step(1);
        n_cmp++;
        if (d16_cnt !== 3'd0 || d16_rd_n !== 1'b1) begin
            n_err++;
            $display("FAIL ft2_discard: cnt=%0d rd=%b want 0 1", d16_cnt, d16_rd_n);
        end
        step(2);
        n_cmp++;
        if (d16_a !== 20'h30100 || d16_ale !== 1'b1) begin
            n_err++;
            $display("FAIL ft2_reload: a=%h ale=%b want 30100 1", d16_a, d16_ale);
        end
        sb.push_back({mb(20'h30100), 20'h30100});
        sb.push_back({mb(20'h30101), 20'h30101});
        step(3);
        suspend = 1'b1;
        n_cmp++;
        if (d16_cnt !== 3'd2) begin
            n_err++;
            $display("FAIL ft2_push: cnt=%0d want 2", d16_cnt);
        end
        test_drain();
    endtask

    task automatic test_wrap_pushpop();
        logic [27:0] e;
        step(6);
        do_flush(16'h4000, 16'hFFFF);
        suspend = 1'b0;
        step(1);
        n_cmp++;
        if (d16_a !== 20'h4FFFF || d16_bhe_n !== 1'b0 || d16_ale !== 1'b1 || d8_a !== 20'h4FFFF) begin
            n_err++;
            $display("FAIL wrap_t1: a16=%h bhe=%b ale=%b a8=%h want 4ffff 0 1 4ffff", d16_a, d16_bhe_n, d16_ale, d8_a);
        end
        sb.push_back({mb(20'h4FFFF), 20'h4FFFF});
        step(3);
        n_cmp++;
        if (d16_cnt !== 3'd1) begin
            n_err++;
            $display("FAIL wrap_single: cnt=%0d want 1", d16_cnt);
        end
        step(2);
        n_cmp++;
        if (d16_a !== 20'h40000 || d16_ale !== 1'b1 || d8_a !== 20'h40000) begin
            n_err++;
            $display("FAIL wrap_next: a16=%h ale=%b a8=%h want 40000 1 40000", d16_a, d16_ale, d8_a);
        end
        sb.push_back({mb(20'h40000), 20'h40000});
        sb.push_back({mb(20'h40001), 20'h40001});
        step(3);
        n_cmp++;
        if (d16_cnt !== 3'd3 || d8_cnt !== 3'd2) begin
            n_err++;
            $display("FAIL wrap_counts: d16=%0d d8=%0d want 3 2", d16_cnt, d8_cnt);
        end
        step(4);
        e = sb.pop_front();
        n_cmp++;
        if (d16_top !== e[27:20] || d16_topa !== e[19:0]) begin
            n_err++;
            $display("FAIL wrap_head: got %h@%h want %h@%h", d16_top, d16_topa, e[27:20], e[19:0]);
        end
        adv = 1'b1;
        step(1);
        adv = 1'b0;
        suspend = 1'b1;
        n_cmp++;
        if (d8_cnt !== 3'd2 || d8_rd_n !== 1'b1 || d16_cnt !== 3'd2) begin
            n_err++;
            $display("FAIL push_pop: d8 cnt=%0d rd=%b d16 cnt=%0d want 2 1 2", d8_cnt, d8_rd_n, d16_cnt);
        end
        test_drain();
    endtask

    task automatic test_reset_midcycle();
        do_flush(16'h0000, 16'h0000);
        suspend = 1'b0;
        step(2);
        n_cmp++;
        if (d16_rd_n !== 1'b0) begin
            n_err++;
            $display("FAIL mid_t2: rd=%b want 0", d16_rd_n);
        end
        rst = 1'b1; tick = 1'b0;
        step(1);
        n_cmp++;
        if ({d16_a, d16_ale, d16_rd_n, d16_bhe_n, d16_cnt, d16_top, d16_topa} !== {20'h0, 3'b011, 3'd0, 8'h0, 20'h0}) begin
            n_err++;
            $display("FAIL mid_reset: a=%h ale=%b rd=%b bhe=%b cnt=%0d top=%h topa=%h want idle/zero", d16_a, d16_ale, d16_rd_n, d16_bhe_n, d16_cnt, d16_top, d16_topa);
        end
        rst = 1'b0; tick = 1'b1; suspend = 1'b1;
        step(1);
    endtask

    initial begin
        test_reset();
        test_fill_8088();
        test_flush_odd();
        test_wait_states();
        test_flush_t2();
        test_wrap_pushpop();
        test_reset_midcycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
